shift_pipe_n: RTL and testbench
===============================

SHIFT_PIPE_N -- requirements
Module: shift_pipe_n

Interface
REQ-001 Parameter WIDTH, default 4, data width of each stage in bits.
REQ-002 Parameter DEPTH, default 3, number of register stages (legal range 2..16).
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST  input  1  synchronous, active-low reset.
REQ-005 Ce  input  1  clock enable for shifting.
REQ-006 Din  input  WIDTH  serial data into the entry stage.
REQ-007 Din_vld  input  1  valid flag accompanying Din.
REQ-008 Dir  input  1  shift direction: 0 forward (stage 0 to DEPTH-1), 1 reverse (DEPTH-1 to 0).
REQ-009 Load  input  1  parallel-load strobe.
REQ-010 Par_in  input  DEPTH*WIDTH  parallel load data; stage k occupies bits [k*WIDTH +: WIDTH].
REQ-011 Flush  input  1  clears all stage valid flags.
REQ-012 Dout  output  WIDTH  exit-stage data: stage DEPTH-1 when Dir=0, stage 0 when Dir=1.
REQ-013 Dout_vld  output  1  valid flag of the exit stage.
REQ-014 Tap_sel  input  clog2(DEPTH)  stage index for the tap port.
REQ-015 Tap_out  output  WIDTH  data of stage Tap_sel, registered (one-cycle latency).
REQ-016 Fill_cnt  output  clog2(DEPTH+1)  number of stages holding valid data.

Function
REQ-017 Per-cycle priority SHALL be: RST low > Flush > Load > Ce shift > hold.
REQ-018 Ce=1, Dir=0: stage k+1 takes stage k; stage 0 takes Din/Din_vld; data and valid move together.
REQ-019 Ce=1, Dir=1: stage k-1 takes stage k; stage DEPTH-1 takes Din/Din_vld.
REQ-020 Forward latency: Din accepted on a Ce edge SHALL appear at Dout after exactly DEPTH Ce-active edges; Ce=0 cycles stall without loss.
REQ-021 Load=1 (regardless of Ce): every stage takes its Par_in slice and its valid flag is set to 1; Fill_cnt becomes DEPTH next cycle.
REQ-022 Flush=1: all valid flags cleared, data registers unchanged, Fill_cnt=0 next cycle; simultaneous Load/Ce ignored.
REQ-023 Dir change takes effect on the same edge it is sampled; no data is lost or duplicated on reversal.
REQ-024 Fill_cnt SHALL equal the population count of stage valid flags, registered, consistent with stage contents after each edge.
REQ-025 Data shifted out of the exit stage is discarded; no overflow flag.
REQ-026 Tap_sel >= DEPTH SHALL yield Tap_out=0.

Reset
REQ-027 With RST low at a rising edge: all stage data, valid flags, Tap_out, Dout, Dout_vld and Fill_cnt SHALL be 0.
REQ-028 Reset mid-shift SHALL discard all in-flight data; first post-reset Ce edge behaves as from empty.

Configuration
REQ-029 Macro SHIFT_PIPE_TAP_EN defined: Tap_sel/Tap_out present and functional per REQ-015/026.
REQ-030 Macro SHIFT_PIPE_TAP_EN undefined: tap logic absent, Tap_out tied to 0, Tap_sel ignored; all other behaviour identical.

Structure
REQ-031 Package shift_pipe_pkg SHALL hold direction constants DIR_FWD=0/DIR_REV=1 and a clog2-based width helper.
REQ-032 Sub-module shift_stage (one WIDTH-bit data + valid register with Ce, load, flush, sync active-low RST) SHALL be instantiated DEPTH times via generate.

Verification (WIDTH=4, DEPTH=3)
REQ-033 Reset, then Din=0x1,0x2,0x3 with Din_vld=1, Ce=1, Dir=0 -> Dout=0x1 with Dout_vld=1 on 3rd edge after first, then 0x2, 0x3; Fill_cnt 1,2,3.
REQ-034 Same stream with Ce toggling 1,0,1,0... -> identical Dout sequence, each value held through Ce=0 cycles.
REQ-035 Load Par_in=0x321 -> stages 0x1,0x2,0x3, Fill_cnt=3; then Dir=1, Ce=1, Din_vld=0 -> Dout=0x1,0x2,0x3 on successive edges, Fill_cnt 3,2,1,0.
REQ-036 Full pipe, Flush=1 with Load=1 same cycle -> Fill_cnt=0, Dout_vld=0, data unchanged.
REQ-037 After Load 0x321, Tap_sel=2 -> Tap_out=0x3 one cycle later; Tap_sel=3 -> 0x0; with macro undefined Tap_out stays 0.
REQ-038 RST low mid-stream after two Ce edges -> all outputs 0 next edge; restarted stream reproduces REQ-033.

Source files
------------

// File: rtl/shift_pipe_pkg.sv
// Shared constants and width helper for the shift_pipe_n pipeline.
package shift_pipe_pkg;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Bit width needed to index n values; never narrower than one bit.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One pipeline stage: WIDTH-bit data plus valid flag; flush > load > shift > hold.
// vld_nxt exposes the flag's next value so the parent can register a population count.
module shift_stage
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ce,
    input  logic             load,
    input  logic             flush,
    input  logic [WIDTH-1:0] shift_dat,
    input  logic             shift_vld,
    input  logic [WIDTH-1:0] par_dat,
    output logic [WIDTH-1:0] dat_out,
    output logic             vld_out,
    output logic             vld_nxt
);

    logic [WIDTH-1:0] dat_d, dat_q;
    logic             vld_d, vld_q;

    // Flush only drops the valid flag; the data register keeps its contents.
    always_comb begin
        dat_d = dat_q;
        vld_d = vld_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (load) begin
            dat_d = par_dat;
            vld_d = 1'b1;
        end else if (ce) begin
            dat_d = shift_dat;
            vld_d = shift_vld;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            dat_q <= '0;
            vld_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
        end
    end

    assign dat_out = dat_q;
    assign vld_out = vld_q;
    assign vld_nxt = vld_d;

endmodule

// File: rtl/shift_pipe_n.sv
// Bidirectional DEPTH-stage shift pipeline with parallel load, flush and registered fill count.
// Optional registered tap port enabled by macro SHIFT_PIPE_TAP_EN; otherwise Tap_out is tied to 0.
module shift_pipe_n
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          Ce,
    input  logic [WIDTH-1:0]              Din,
    input  logic                          Din_vld,
    input  logic                          Dir,
    input  logic                          Load,
    input  logic [DEPTH*WIDTH-1:0]        Par_in,
    input  logic                          Flush,
    output logic [WIDTH-1:0]              Dout,
    output logic                          Dout_vld,
    input  logic [clog2w(DEPTH)-1:0]      Tap_sel,
    output logic [WIDTH-1:0]              Tap_out,
    output logic [clog2w(DEPTH+1)-1:0]    Fill_cnt
);

    localparam int FILL_W = clog2w(DEPTH + 1);

    logic [WIDTH-1:0] stage_dat [DEPTH];
    logic [DEPTH-1:0] stage_vld;
    logic [DEPTH-1:0] stage_vld_nxt;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] fwd_dat, rev_dat, src_dat;
        logic             fwd_vld, rev_vld, src_vld;

        // Forward feeds from the lower neighbour, reverse from the upper one.
        if (k == 0) begin : g_fwd_entry
            assign fwd_dat = Din;
            assign fwd_vld = Din_vld;
        end else begin : g_fwd_link
            assign fwd_dat = stage_dat[k-1];
            assign fwd_vld = stage_vld[k-1];
        end

        if (k == DEPTH - 1) begin : g_rev_entry
            assign rev_dat = Din;
            assign rev_vld = Din_vld;
        end else begin : g_rev_link
            assign rev_dat = stage_dat[k+1];
            assign rev_vld = stage_vld[k+1];
        end

        assign src_dat = (Dir == DIR_REV) ? rev_dat : fwd_dat;
        assign src_vld = (Dir == DIR_REV) ? rev_vld : fwd_vld;

        shift_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .CLK       (CLK),
            .RST       (RST),
            .ce        (Ce),
            .load      (Load),
            .flush     (Flush),
            .shift_dat (src_dat),
            .shift_vld (src_vld),
            .par_dat   (Par_in[k*WIDTH +: WIDTH]),
            .dat_out   (stage_dat[k]),
            .vld_out   (stage_vld[k]),
            .vld_nxt   (stage_vld_nxt[k])
        );
    end

    assign Dout     = (Dir == DIR_REV) ? stage_dat[0] : stage_dat[DEPTH-1];
    assign Dout_vld = (Dir == DIR_REV) ? stage_vld[0] : stage_vld[DEPTH-1];

    // Counting the next-state flags keeps the count aligned with the stages after each edge.
    logic [FILL_W-1:0] fill_cnt_d, fill_cnt_q;

    always_comb begin
        fill_cnt_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fill_cnt_d = fill_cnt_d + FILL_W'(stage_vld_nxt[k]);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            fill_cnt_q <= '0;
        end else begin
            fill_cnt_q <= fill_cnt_d;
        end
    end

    assign Fill_cnt = fill_cnt_q;

`ifdef SHIFT_PIPE_TAP_EN
    logic [WIDTH-1:0] tap_out_d, tap_out_q;

    always_comb begin
        tap_out_d = '0;
        if (int'(Tap_sel) < DEPTH) begin
            tap_out_d = stage_dat[Tap_sel];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            tap_out_q <= '0;
        end else begin
            tap_out_q <= tap_out_d;
        end
    end

    assign Tap_out = tap_out_q;
`else
    logic unused_tap_sel;
    assign unused_tap_sel = ^Tap_sel;
    assign Tap_out        = '0;
`endif

endmodule

// File: tb/tb_shift_pipe_n.sv
// Directed bench for shift_pipe_n at WIDTH=4, DEPTH=3; tap expectations follow SHIFT_PIPE_TAP_EN.
module tb_shift_pipe_n;

    localparam int WIDTH = 4;
    localparam int DEPTH = 3;
`ifdef SHIFT_PIPE_TAP_EN
    localparam bit TAP = 1'b1;
`else
    localparam bit TAP = 1'b0;
`endif

    logic                   CLK = 1'b0;
    logic                   RST;
    logic                   Ce;
    logic [WIDTH-1:0]       Din;
    logic                   Din_vld;
    logic                   Dir;
    logic                   Load;
    logic [DEPTH*WIDTH-1:0] Par_in;
    logic                   Flush;
    logic [WIDTH-1:0]       Dout;
    logic                   Dout_vld;
    logic [1:0]             Tap_sel;
    logic [WIDTH-1:0]       Tap_out;
    logic [1:0]             Fill_cnt;

    int total  = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    shift_pipe_n #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Ce       (Ce),
        .Din      (Din),
        .Din_vld  (Din_vld),
        .Dir      (Dir),
        .Load     (Load),
        .Par_in   (Par_in),
        .Flush    (Flush),
        .Dout     (Dout),
        .Dout_vld (Dout_vld),
        .Tap_sel  (Tap_sel),
        .Tap_out  (Tap_out),
        .Fill_cnt (Fill_cnt)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Data is only compared while the exit stage is valid.
    task automatic chk_out(input string tag, input logic [3:0] d, input logic v, input logic [1:0] f);
        chk({tag, ".vld"}, 16'(Dout_vld), 16'(v));
        chk({tag, ".fill"}, 16'(Fill_cnt), 16'(f));
        if (v) chk({tag, ".dout"}, 16'(Dout), 16'(d));
    endtask

    task automatic run_stream(input string p);
        Ce = 1'b1; Dir = 1'b0; Din_vld = 1'b1; Din = 4'h1;
        tick(); chk_out({p, ".e1"}, 4'h0, 1'b0, 2'd1);
        Din = 4'h2;
        tick(); chk_out({p, ".e2"}, 4'h0, 1'b0, 2'd2);
        Din = 4'h3;
        tick(); chk_out({p, ".e3"}, 4'h1, 1'b1, 2'd3);
        Din_vld = 1'b0; Din = 4'h0;
        tick(); chk_out({p, ".e4"}, 4'h2, 1'b1, 2'd2);
        tick(); chk_out({p, ".e5"}, 4'h3, 1'b1, 2'd1);
        tick(); chk_out({p, ".e6"}, 4'h0, 1'b0, 2'd0);
        Ce = 1'b0;
    endtask

    initial begin
        RST = 1'b0; Ce = 1'b0; Din = '0; Din_vld = 1'b0; Dir = 1'b0;
        Load = 1'b0; Par_in = '0; Flush = 1'b0; Tap_sel = '0;

        // Reset state
        tick(); tick();
        chk("rst.dout", 16'(Dout), 16'h0);
        chk("rst.vld", 16'(Dout_vld), 16'h0);
        chk("rst.fill", 16'(Fill_cnt), 16'h0);
        chk("rst.tap", 16'(Tap_out), 16'h0);
        RST = 1'b1;

        run_stream("fwd");

        // Ce toggling: stalls hold state and ignore Din
        Ce = 1'b1; Din = 4'h1; Din_vld = 1'b1;
        tick(); chk_out("ce.1", 4'h0, 1'b0, 2'd1);
        Ce = 1'b0; Din = 4'hF;
        tick(); chk_out("ce.2", 4'h0, 1'b0, 2'd1);
        Ce = 1'b1; Din = 4'h2;
        tick(); chk_out("ce.3", 4'h0, 1'b0, 2'd2);
        Ce = 1'b0; Din = 4'hE;
        tick(); chk_out("ce.4", 4'h0, 1'b0, 2'd2);
        Ce = 1'b1; Din = 4'h3;
        tick(); chk_out("ce.5", 4'h1, 1'b1, 2'd3);
        Ce = 1'b0; Din = 4'hD;
        tick(); chk_out("ce.6", 4'h1, 1'b1, 2'd3);
        Ce = 1'b1; Din = 4'h0; Din_vld = 1'b0;
        tick(); chk_out("ce.7", 4'h2, 1'b1, 2'd2);
        Ce = 1'b0;
        tick(); chk_out("ce.8", 4'h2, 1'b1, 2'd2);
        Ce = 1'b1;
        tick(); chk_out("ce.9", 4'h3, 1'b1, 2'd1);
        Ce = 1'b0;
        tick(); chk_out("ce.10", 4'h3, 1'b1, 2'd1);
        Ce = 1'b1;
        tick(); chk_out("ce.11", 4'h0, 1'b0, 2'd0);
        Ce = 1'b0;

        // Load wins over a simultaneous shift
        Par_in = 12'h321; Load = 1'b1; Ce = 1'b1; Din = 4'h9; Din_vld = 1'b1;
        tick(); Load = 1'b0; Ce = 1'b0; Din_vld = 1'b0;
        chk_out("load", 4'h3, 1'b1, 2'd3);

        // Tap port
        Tap_sel = 2'd2;
        tick(); chk("tap.sel2", 16'(Tap_out), TAP ? 16'h3 : 16'h0);
        Tap_sel = 2'd3;
        tick(); chk("tap.sel3", 16'(Tap_out), 16'h0);
        Tap_sel = 2'd0;
        tick(); chk("tap.sel0", 16'(Tap_out), TAP ? 16'h1 : 16'h0);

        // Flush beats Load and Ce; data registers keep 0x321
        Flush = 1'b1; Load = 1'b1; Ce = 1'b1; Par_in = 12'hABC;
        tick(); Flush = 1'b0; Load = 1'b0; Ce = 1'b0;
        chk("flush.fill", 16'(Fill_cnt), 16'h0);
        chk("flush.vld", 16'(Dout_vld), 16'h0);
        chk("flush.dout_fwd", 16'(Dout), 16'h3);
        Dir = 1'b1; #1;
        chk("flush.dout_rev", 16'(Dout), 16'h1);
        Dir = 1'b0;

        // Reverse drain after parallel load
        Par_in = 12'h321; Load = 1'b1;
        tick(); Load = 1'b0;
        Dir = 1'b1; #1;
        chk_out("rev.0", 4'h1, 1'b1, 2'd3);
        Ce = 1'b1; Din_vld = 1'b0; Din = 4'h0;
        tick(); chk_out("rev.1", 4'h2, 1'b1, 2'd2);
        tick(); chk_out("rev.2", 4'h3, 1'b1, 2'd1);
        tick(); chk_out("rev.3", 4'h0, 1'b0, 2'd0);
        Ce = 1'b0; Dir = 1'b0;

        // Reset mid-stream discards in-flight data
        Ce = 1'b1; Din_vld = 1'b1; Din = 4'h1;
        tick(); Din = 4'h2;
        tick(); chk("mid.fill", 16'(Fill_cnt), 16'h2);
        RST = 1'b0;
        tick(); RST = 1'b1; Ce = 1'b0; Din_vld = 1'b0;
        chk("mrst.dout", 16'(Dout), 16'h0);
        chk("mrst.vld", 16'(Dout_vld), 16'h0);
        chk("mrst.fill", 16'(Fill_cnt), 16'h0);
        chk("mrst.tap", 16'(Tap_out), 16'h0);
        Dir = 1'b1; #1;
        chk("mrst.stage0", 16'(Dout), 16'h0);
        Dir = 1'b0;

        run_stream("post");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
